// File: rtl/nibble_serial_adder_seq_if.sv
// Handshake bus of the nibble-serial add/subtract sequencer: operand port,
// result port and the narrow link to the shared 4-bit adder stage.
interface nibble_serial_adder_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;

  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_cin;
  logic [3:0]       add_s;
  logic             add_cout;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  // Master is the surrounding system: operand source, result sink and adder stage.
  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready, add_s, add_cout,
    input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready, add_s, add_cout,
    output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/nibble_serial_adder_seq.sv
// Builds a WIDTH-bit add/subtract out of one external 4-bit adder by walking
// the operands a nibble per cycle, LSB first, with the carry kept in a register.
module nibble_serial_adder_seq #(
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  nibble_serial_adder_seq_if.slave  bus
);
  localparam int NSLICE = WIDTH / 4;
  localparam int IDX_W  = $clog2(NSLICE);
  localparam int MSB    = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic             out_valid_q;
  logic             out_cout_q;
  logic             out_ovf_q;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic             last_slice;
  logic             run;

  // Overflow only when both operands share a sign and the result sign differs.
  function automatic logic ovf_f(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    sum_d = sum_q;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib            = a_q[4*i +: 4];
        b_nib            = b_q[4*i +: 4];
        sum_d[4*i +: 4]  = bus.add_s;
      end
    end
  end

  assign idx_d      = idx_q + IDX_W'(1);
  assign last_slice = (idx_q == IDX_W'(NSLICE - 1));
  assign run        = (state_q == RUN);

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.add_a     = run ? a_nib : 4'h0;
  assign bus.add_b     = run ? b_nib : 4'h0;
  assign bus.add_cin   = run & carry_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = out_cout_q;
  assign bus.out_ovf   = out_ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            // Subtract is A + ~B + 1, so the inversion and the +1 happen at capture.
            a_q     <= bus.in_a;
            b_q     <= bus.in_sub ? ~bus.in_b : bus.in_b;
            carry_q <= bus.in_sub | bus.in_cin;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= bus.add_cout;
          idx_q   <= idx_d;
          if (last_slice) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_cout_q  <= bus.add_cout;
            out_ovf_q   <= ovf_f(a_q[MSB], b_q[MSB], bus.add_s[3]);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/nibble_serial_adder_seq.md
Name: nibble_serial_adder_seq

Overview:
- Multi-word add/subtract sequencer that sits directly upstream of the 4-bit ripple adder stage and also consumes its result.
- Accepts a WIDTH-bit operand pair over a valid/ready handshake.
- Feeds the 4-bit adder one nibble per cycle, least significant first, chaining the carry through a register.
- Assembles the returned nibbles into a WIDTH-bit result, presented on a valid/ready output port.
- Lets the team build wide adders from the single 4-bit stage without widening it.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 8.
- NSLICE, WIDTH/4, number of nibble slices; derived, never overridden.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  sequencer can accept operands.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in for add; ignored when in_sub=1.
- in_sub  input  1  1 = compute A - B.
- add_a  output  4  nibble of A to the adder stage.
- add_b  output  4  nibble of effective B to the adder stage.
- add_cin  output  1  chained carry to the adder stage.
- add_s  input  4  sum nibble from the adder stage; combinational, same cycle.
- add_cout  input  1  carry-out from the adder stage; combinational, same cycle.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  WIDTH  result.
- out_cout  output  1  final carry-out; for subtract, 1 = no borrow.
- out_ovf  output  1  signed two's-complement overflow.

Behaviour:
- Clock and reset are decided: one clock; reset is asynchronous and active-low. The ports are clk and rst_n; the polarity and synchronicity are fixed.
- Reset (rst_n=0, immediate, no clock needed):
  - state=IDLE; slice index=0.
  - operand, carry and sum registers=0.
  - out_valid=0, out_sum=0, out_cout=0, out_ovf=0.
  - add_a/add_b/add_cin=0.
  - in_ready=1.
- in_ready is combinational and equals (state==IDLE).
- State IDLE:
  - Operands are accepted on the edge where in_valid && in_ready.
  - Capture a_reg=in_a.
  - Capture b_reg = in_sub ? ~in_b : in_b.
  - Capture carry = in_sub ? 1 : in_cin.
  - Set idx=0 and go to RUN.
- State RUN:
  - Each cycle drive add_a=a_reg[4*idx+:4], add_b=b_reg[4*idx+:4], add_cin=carry.
  - At the edge, write sum[4*idx+:4]=add_s, carry=add_cout, idx=idx+1.
  - At the edge that writes slice NSLICE-1, go to DONE.
  - Capture out_cout=add_cout.
  - Capture out_ovf = (a_reg[MSB]==b_reg[MSB]) && (add_s[3]!=a_reg[MSB]).
- State DONE:
  - out_valid=1; out_sum, out_cout and out_ovf are held stable.
  - On the edge with out_ready=1, go to IDLE and drop out_valid.
  - Inputs presented while in DONE are not accepted.
- Outside RUN, add_a/add_b/add_cin are driven to 0.
- Latency:
  - out_valid rises exactly NSLICE edges after the accept edge (4 for WIDTH=16).
  - Earliest next accept is the edge after the out_ready handshake, because in_ready is 1 only in IDLE.
  - Throughput is one operation per NSLICE+2 cycles.
- Arithmetic is modulo 2^WIDTH. The result must equal in_a + in_b + in_cin, or in_a + ~in_b + 1 for subtract, with the WIDTH+1-th bit on out_cout.
- Reset mid-operation: all partial state is discarded. The first accept after rst_n rises starts fresh from slice 0.
- in_valid held high with changing data during RUN/DONE has no effect; only the value at the accept edge matters.

Test Plan (WIDTH=16, bench instantiates the 4-bit adder stage on the add_* ports):
- 0x1234 + 0x0FCD, cin=0, sub=0 -> out_sum=0x2201, cout=0, ovf=0; out_valid exactly 4 edges after accept.
- 0x0FFF + 0x0000, cin=1 -> 0x1000, cout=0 (carry ripples across 3 slice boundaries). Then 0xFFFF + 0x0001, cin=0 -> 0x0000, cout=1, ovf=0.
- 0x7FFF + 0x0001 -> 0x8000, cout=0, ovf=1. Then 0x8000 + 0x8000 -> 0x0000, cout=1, ovf=1.
- Subtract: 0x0005 - 0x0007 (sub=1, in_cin=1 ignored) -> 0xFFFE, cout=0, ovf=0. Then 0x0007 - 0x0005 -> 0x0002, cout=1.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid, with in_valid=1 and new data presented. Required: out_sum/out_cout/out_ovf stable, in_ready=0, new data not taken. With out_ready=1, in_ready=1 next cycle and the new pair is accepted correctly.
- Pull rst_n low after 2 slices of 0x1234+0x0FCD. Required: out_valid=0, in_ready=1, add_* = 0 immediately. After release, 0x0001+0x0001 -> 0x0002 with no residue.
